y_result_drain: RTL and testbench

Hardware result reader for the systolic-array datapath: after a `top_pd` matrix job completes, it walks the result rows by driving `y_index`, captures each N-wide `y_out` row and serialises it onto a valid/ready word stream in row-major order. It replaces the bench-side "read data from Y" loop and sits between `top_pd` and the downstream consumer (DMA or host FIFO).

---
 rtl/systolic_array_pkg.sv | 19 +
 rtl/y_row_buffer.sv | 37 +++
 rtl/y_result_drain.sv | 195 +++++++++++++++++++
 tb/tb_y_result_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// ---------------------------------------------------------------------------
// systolic_array_pkg
// Shared types for the systolic-array datapath.
//   word_t     : one IEEE-754 single-precision word
//   drain_st_e : state encoding of the y_result_drain sequencer
// ---------------------------------------------------------------------------
package systolic_array_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    DRAIN_IDLE  = 3'd0,
    DRAIN_SET   = 3'd1,
    DRAIN_LATCH = 3'd2,
    DRAIN_SEND  = 3'd3,
    DRAIN_DONE  = 3'd4
  } drain_st_e;

endpackage

// File: rtl/y_row_buffer.sv
// ---------------------------------------------------------------------------
// y_row_buffer
// N-word register file holding one result row: parallel load, indexed read.
// Ports:
//   clk, n_rst  clock / asynchronous active-low reset (clears the buffer)
//   load        capture row_in on the next clock edge
//   row_in      N words to capture
//   rd_idx      word select for rd_data
//   rd_data     selected word (combinational read)
// ---------------------------------------------------------------------------
module y_row_buffer
  import systolic_array_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  word_t [N-1:0]     row_in,
  input  logic  [IW-1:0]    rd_idx,
  output word_t             rd_data
);

  word_t [N-1:0] mem;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem <= '0;
    end else if (load) begin
      mem <= row_in;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/y_result_drain.sv
// ---------------------------------------------------------------------------
// y_result_drain
// Walks the result rows of a finished top_pd job by driving y_index_o,
// captures each N-wide row and streams it out word by word (row-major) on a
// valid/ready interface.
// Ports:
//   clk, n_rst         clock / asynchronous active-low reset
//   start_i            drain request pulse (honoured only in IDLE, sa_busy_i low)
//   sa_busy_i          top_pd busy
//   y_in               result row selected by y_index_o
//   y_index_o          row select to top_pd
//   m_valid_o/m_ready_i stream handshake
//   m_data_o           result word
//   m_row_o, m_col_o   coordinates of m_data_o
//   m_last_o           marks word (N-1, N-1)
//   busy_o             drain in progress
//   done_o             one-cycle pulse after the final handshake
// Build option:
//   Y_DRAIN_PREFETCH_EN  second row buffer; row r+1 is fetched while row r
//                        streams, giving a gapless stream. Needs N >= 2.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start_i with sa_busy_i low
// SET    | y_index_o driven with the row, y_in settling
// LATCH  | y_in copied into the row buffer
// SEND   | buffer[col] presented, col advances on each handshake
// DONE   | done_o pulse, back to IDLE
// ---------------------------------------------------------------------------
module y_result_drain
  import systolic_array_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_i,
  input  logic              sa_busy_i,
  input  word_t [N-1:0]     y_in,
  output logic  [IW-1:0]    y_index_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output word_t             m_data_o,
  output logic  [IW-1:0]    m_row_o,
  output logic  [IW-1:0]    m_col_o,
  output logic              m_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  drain_st_e      state;
  logic [IW-1:0]  row;
  logic [IW-1:0]  col;
  logic [IW-1:0]  row_inc;
  logic           hs;
  logic           row_end;
  word_t          rd_word;

  assign row_inc = row + IW'(1);
  assign hs      = m_valid_o && m_ready_i;
  assign row_end = (state == DRAIN_SEND) && hs && (col == LAST_IDX);

`ifdef Y_DRAIN_PREFETCH_EN
  // pf_cnt is a settle timer for the prefetched row: loaded with 2 when
  // y_index_o moves ahead, the inactive buffer captures at terminal count 1,
  // mirroring the SET/LATCH spacing of the first row.
  logic [IW-1:0]  row_inc2;
  logic [1:0]     pf_cnt;
  logic           pf_cap;
  logic           buf_sel;
  logic           load0;
  logic           load1;
  word_t          rd0;
  word_t          rd1;

  assign row_inc2 = row + IW'(2);
  assign pf_cap   = (pf_cnt == 2'd1);
  assign load0    = (state == DRAIN_LATCH) || (pf_cap && buf_sel);
  assign load1    = pf_cap && !buf_sel;
  assign rd_word  = buf_sel ? rd1 : rd0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pf_cnt  <= 2'd0;
      buf_sel <= 1'b0;
    end else if (state == DRAIN_IDLE) begin
      pf_cnt  <= 2'd0;
      buf_sel <= 1'b0;
    end else if (state == DRAIN_LATCH && row != LAST_IDX) begin
      pf_cnt <= 2'd2;
    end else if (row_end && row != LAST_IDX) begin
      buf_sel <= ~buf_sel;
      pf_cnt  <= (row_inc != LAST_IDX) ? 2'd2 : 2'd0;
    end else if (pf_cnt != 2'd0) begin
      pf_cnt <= pf_cnt - 2'd1;
    end
  end

  y_row_buffer #(.N(N), .IW(IW)) u_buf0 (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (load0),
    .row_in  (y_in),
    .rd_idx  (col),
    .rd_data (rd0)
  );

  y_row_buffer #(.N(N), .IW(IW)) u_buf1 (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (load1),
    .row_in  (y_in),
    .rd_idx  (col),
    .rd_data (rd1)
  );
`else
  y_row_buffer #(.N(N), .IW(IW)) u_buf0 (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (state == DRAIN_LATCH),
    .row_in  (y_in),
    .rd_idx  (col),
    .rd_data (rd_word)
  );
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= DRAIN_IDLE;
      row       <= '0;
      col       <= '0;
      y_index_o <= '0;
    end else begin
      case (state)
        DRAIN_IDLE: begin
          if (start_i && !sa_busy_i) begin
            state     <= DRAIN_SET;
            row       <= '0;
            col       <= '0;
            y_index_o <= '0;
          end
        end
        DRAIN_SET: begin
          state <= DRAIN_LATCH;
        end
        DRAIN_LATCH: begin
          state <= DRAIN_SEND;
          col   <= '0;
`ifdef Y_DRAIN_PREFETCH_EN
          if (row != LAST_IDX) y_index_o <= row_inc;
`endif
        end
        DRAIN_SEND: begin
          if (hs) begin
            if (col == LAST_IDX) begin
              col <= '0;
              if (row == LAST_IDX) begin
                state <= DRAIN_DONE;
              end else begin
                row <= row_inc;
`ifdef Y_DRAIN_PREFETCH_EN
                // Next row is already buffered; start fetching the one after.
                if (row_inc != LAST_IDX) y_index_o <= row_inc2;
`else
                y_index_o <= row_inc;
                state     <= DRAIN_SET;
`endif
              end
            end else begin
              col <= col + IW'(1);
            end
          end
        end
        DRAIN_DONE: begin
          state <= DRAIN_IDLE;
        end
        default: begin
          state <= DRAIN_IDLE;
        end
      endcase
    end
  end

  assign m_valid_o = (state == DRAIN_SEND);
  assign m_data_o  = m_valid_o ? rd_word : '0;
  assign m_row_o   = row;
  assign m_col_o   = col;
  assign m_last_o  = m_valid_o && (row == LAST_IDX) && (col == LAST_IDX);
  assign busy_o    = (state != DRAIN_IDLE);
  assign done_o    = (state == DRAIN_DONE);

endmodule

// File: tb/tb_y_result_drain.sv
module tb_y_result_drain;
  import systolic_array_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
`ifdef Y_DRAIN_PREFETCH_EN
  localparam int SPAN = 15;
`else
  localparam int SPAN = 21;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } exp_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start_i;
  logic          sa_busy_i;
  word_t [N-1:0] y_in;
  logic [IW-1:0] y_index_o;
  logic          m_valid_o;
  logic          m_ready_i;
  word_t         m_data_o;
  logic [IW-1:0] m_row_o;
  logic [IW-1:0] m_col_o;
  logic          m_last_o;
  logic          busy_o;
  logic          done_o;

  // Y = X * I with X = 1..16 row-major, as IEEE-754 singles.
  logic [31:0] fval [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};

  exp_t sb[$];
  int   hs_log[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   hs_count = 0;
  int   ready_mode = 0;
  logic        hold_valid = 1'b0;
  logic [31:0] held_data;
  logic [4:0]  held_pos;

  y_result_drain #(.N(N), .IW(IW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start_i   (start_i),
    .sa_busy_i (sa_busy_i),
    .y_in      (y_in),
    .y_index_o (y_index_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_data_o  (m_data_o),
    .m_row_o   (m_row_o),
    .m_col_o   (m_col_o),
    .m_last_o  (m_last_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    y_in = '0;
    for (int c = 0; c < N; c++) y_in[c] = fval[int'(y_index_o) * N + c];
  end

  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_ready_i = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_all();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        sb.push_back('{fval[r*N+c], 2'(r), 2'(c), (r == N-1 && c == N-1)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int base;
    int k;
    base = done_cnt;
    k = 0;
    while (done_cnt == base && k < budget) begin
      tick(1);
      k++;
    end
    check({name, "_done_seen"}, 64'(done_cnt != base), 64'd1);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        hold_valid = 1'b0;
      end else begin
        if (hold_valid) begin
          check("stall_valid_held", 64'(m_valid_o), 64'd1);
          check("stall_data_stable", 64'(m_data_o), 64'(held_data));
          check("stall_pos_stable", 64'({m_row_o, m_col_o, m_last_o}), 64'(held_pos));
        end
        hold_valid = 1'b0;
        if (m_valid_o) begin
          if (m_ready_i) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: actual=%0h expected=none", m_data_o);
            end else begin
              e = sb.pop_front();
              check("word_data", 64'(m_data_o), 64'(e.data));
              check("word_row", 64'(m_row_o), 64'(e.row));
              check("word_col", 64'(m_col_o), 64'(e.col));
              check("word_last", 64'(m_last_o), 64'(e.last));
            end
            hs_count++;
            hs_log.push_back(cyc);
          end else begin
            hold_valid = 1'b1;
            held_data  = m_data_o;
            held_pos   = {m_row_o, m_col_o, m_last_o};
          end
        end
        if (done_o) begin
          done_cnt++;
          if (hs_log.size() > 0) check("done_after_last_hs", 64'(cyc - hs_log[$]), 64'd1);
          check("sb_empty_at_done", 64'(sb.size()), 64'd0);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n;
    int base_hs;
    int base_done;
    int k;

    n_rst     = 1'b0;
    start_i   = 1'b0;
    sa_busy_i = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset state
    tick(2);
    check("reset_asserted_outputs",
          64'({y_index_o, m_valid_o, m_data_o, m_row_o, m_col_o, m_last_o, busy_o, done_o}), 64'd0);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_outputs_zero",
            64'({y_index_o, m_valid_o, m_data_o, m_row_o, m_col_o, m_last_o, busy_o, done_o}), 64'd0);
    end

    // Drain with ready held high
    push_all();
    pulse_start();
    check("y_index_after_start", 64'(y_index_o), 64'd0);
    check("busy_after_start", 64'(busy_o), 64'd1);
    lat = 1;
    while (!m_valid_o && lat < 20) begin
      tick(1);
      lat++;
    end
    check("first_valid_latency", 64'(lat), 64'd3);
    wait_done(200, "drain_ready_high");
    n = hs_log.size();
    if (n >= 16) check("drain_span_cycles", 64'(hs_log[n-1] - hs_log[n-16]), 64'(SPAN));
    else check("drain_word_count", 64'(n), 64'd16);
    tick(1);
    check("busy_after_done", 64'(busy_o), 64'd0);

    // Random backpressure
    ready_mode = 1;
    push_all();
    pulse_start();
    wait_done(600, "drain_backpressure");
    ready_mode = 0;
    tick(3);

    // Ignored starts: while sa_busy_i, and during SEND
    sa_busy_i = 1'b1;
    pulse_start();
    sa_busy_i = 1'b0;
    tick(4);
    check("start_ignored_when_sa_busy", 64'(busy_o), 64'd0);
    base_done = done_cnt;
    base_hs = hs_count;
    push_all();
    pulse_start();
    k = 0;
    while (!(m_valid_o && hs_count >= base_hs + 5) && k < 100) begin
      tick(1);
      k++;
    end
    check("reached_send", 64'(m_valid_o), 64'd1);
    pulse_start();
    wait_done(200, "drain_with_extra_start");
    tick(12);
    check("single_done_pulse", 64'(done_cnt - base_done), 64'd1);
    check("idle_after_ignored_start", 64'(busy_o), 64'd0);

    // Asynchronous reset after word 6
    base_done = done_cnt;
    base_hs = hs_count;
    push_all();
    pulse_start();
    k = 0;
    while (hs_count < base_hs + 6 && k < 100) begin
      tick(1);
      k++;
    end
    check("six_words_before_reset", 64'(hs_count - base_hs), 64'd6);
    n_rst = 1'b0;
    #1;
    check("valid_drops_on_reset", 64'(m_valid_o), 64'd0);
    check("busy_drops_on_reset", 64'(busy_o), 64'd0);
    sb.delete();
    tick(3);
    n_rst = 1'b1;
    tick(3);
    check("no_done_after_abort", 64'(done_cnt - base_done), 64'd0);
    push_all();
    pulse_start();
    wait_done(200, "drain_after_reset");

    // Back-to-back drains
    push_all();
    pulse_start();
    wait_done(200, "b2b_first");
    check("y_index_end_of_drain", 64'(y_index_o), 64'(N-1));
    push_all();
    pulse_start();
    check("y_index_restart", 64'(y_index_o), 64'd0);
    wait_done(200, "b2b_second");
    tick(3);

    check("total_done_pulses", 64'(done_cnt), 64'd6);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
